sram_access_sequencer: RTL and testbench

Sequencer for the board's external 256K×16 asynchronous SRAM, behind the LSU's data-memory region. It accepts one 32-bit-wide load/store request at a time from the LSU and breaks it into one or two timed 16-bit SRAM phases. It applies RISC-V byte/half/word lane selection and load sign-extension, and returns a single-cycle acknowledge. The DQ tristate buffer is instantiated at top level from `o_sram_dq`/`o_sram_dq_oe`/`i_sram_dq`.

---
 rtl/sram_pkg.sv | 43 ++++
 rtl/sram_access_sequencer_timer.sv | 30 +++
 rtl/sram_access_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_sram_access_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types, widths and load-extension helper for the external SRAM sequencer.
package sram_pkg;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } sram_state_e;

  // Builds the 32-bit load result from the one or two halfwords read back.
  function automatic logic [31:0] ld_extend(input logic [2:0]  funct3,
                                            input logic        lane_sel,
                                            input logic [15:0] data16_lo,
                                            input logic [15:0] data16_hi);
    logic [7:0]  lane;
    logic [31:0] res;
    lane = lane_sel ? data16_lo[15:8] : data16_lo[7:0];
    case (funct3)
      F3_B:    res = {{24{lane[7]}}, lane};
      F3_BU:   res = {24'h000000, lane};
      F3_H:    res = {{16{data16_lo[15]}}, data16_lo};
      F3_HU:   res = {16'h0000, data16_lo};
      F3_W:    res = {data16_hi, data16_lo};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sram_access_sequencer_timer.sv
// Phase timer: counts down from WAIT_CYCLES so every SRAM phase lasts WAIT_CYCLES+1 cycles.
module sram_phase_timer #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic start,
  output logic last,
  output logic we_window
);

  logic [3:0] cnt_q;

  // Load at phase start, then count down to zero and hold there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= 4'd0;
    end else if (start) begin
      cnt_q <= 4'(WAIT_CYCLES);
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // last: current cycle is the final one of the phase.
  // we_window: the following cycle is still inside the WE-low part of the phase.
  assign last      = (cnt_q == 4'd0);
  assign we_window = (cnt_q >= 4'd2);

endmodule

// File: rtl/sram_access_sequencer.sv
// Splits one LSU load/store into one or two timed 16-bit asynchronous SRAM phases.
module sram_access_sequencer
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ADDR_W-1:0]  i_lsu_addr,
  input  logic [DATA_W-1:0]  i_st_data,
  input  logic               i_lsu_wren,
  input  logic               i_lsu_rden,
  input  logic [2:0]         i_control,
  output logic               o_ready,
  output logic               o_ack,
  output logic               o_err,
  output logic [DATA_W-1:0]  o_ld_data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N,
  output logic [SRAM_DW-1:0] o_sram_dq,
  output logic               o_sram_dq_oe,
  input  logic [SRAM_DW-1:0] i_sram_dq
);

  // Without a hold cycle WE would rise together with the data change.
  if (WAIT_CYCLES == 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("sram_access_sequencer: WAIT_CYCLES must be within 1..15");
  end

  sram_state_e state_q, state_d;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [2:0]         f3_q;
  logic [SRAM_DW-1:0] lo_q;
  logic               err_pend_q;

  logic               accept, req_bad;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_data;
  logic [2:0]         req_f3;
  logic               in_phase_d, rd_phase_d, wr_phase_d, hi_phase, phase_start;
  logic               phase_last, we_window;

  logic               ready_d, ack_d, err_d;
  logic [DATA_W-1:0]  ld_data_d;
  logic [SRAM_AW-1:0] sram_addr_d;
  logic               ce_n_d, we_n_d, oe_n_d, lb_n_d, ub_n_d, dq_oe_d;
  logic [SRAM_DW-1:0] dq_d;

  // An erroring request holds IDLE one extra cycle with ready low before DONE.
  assign accept = (state_q == S_IDLE) && !err_pend_q && (i_lsu_wren || i_lsu_rden);

  // During the accept cycle the phase about to start is described by the live inputs.
  assign req_addr = accept ? i_lsu_addr : addr_q;
  assign req_data = accept ? i_st_data  : data_q;
  assign req_f3   = accept ? i_control  : f3_q;

  // Illegal funct3, misalignment, or unsigned store.
  always_comb begin
    req_bad = 1'b0;
    case (i_control)
      F3_B:    req_bad = 1'b0;
      F3_BU:   req_bad = i_lsu_wren;
      F3_H:    req_bad = i_lsu_addr[0];
      F3_HU:   req_bad = i_lsu_addr[0] || i_lsu_wren;
      F3_W:    req_bad = (i_lsu_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the write request wins when both enables are high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (err_pend_q) begin
          state_d = S_DONE;
        end else if (accept && !req_bad) begin
          state_d = i_lsu_wren ? S_WR_LO : S_RD_LO;
        end
      end
      S_RD_LO: if (phase_last) state_d = (f3_q == F3_W) ? S_RD_HI : S_DONE;
      S_RD_HI: if (phase_last) state_d = S_DONE;
      S_WR_LO: if (phase_last) state_d = (f3_q == F3_W) ? S_WR_HI : S_DONE;
      S_WR_HI: if (phase_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_phase_d  = (state_d == S_RD_LO) || (state_d == S_RD_HI);
  assign wr_phase_d  = (state_d == S_WR_LO) || (state_d == S_WR_HI);
  assign in_phase_d  = rd_phase_d || wr_phase_d;
  assign hi_phase    = (state_d == S_RD_HI) || (state_d == S_WR_HI);
  assign phase_start = in_phase_d && (state_d != state_q);

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .start     (phase_start),
    .last      (phase_last),
    .we_window (we_window)
  );

  // Output logic: next-cycle values of every registered output.
  always_comb begin
    ready_d     = (state_d == S_IDLE) && !(accept && req_bad);
    ack_d       = (state_d == S_DONE);
    err_d       = accept ? req_bad : o_err;
    ld_data_d   = o_ld_data;
    sram_addr_d = SRAM_ADDR;
    dq_d        = o_sram_dq;
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    dq_oe_d     = 1'b0;

    if (in_phase_d) begin
      ce_n_d = 1'b0;
      if (req_f3 == F3_W) begin
        sram_addr_d = {req_addr[ADDR_W-1:2], hi_phase};
      end else begin
        sram_addr_d = req_addr[ADDR_W-1:1];
      end
      if (req_f3 == F3_B || req_f3 == F3_BU) begin
        lb_n_d = req_addr[0];
        ub_n_d = !req_addr[0];
      end else begin
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end

    if (rd_phase_d) begin
      oe_n_d = 1'b0;
    end

    if (wr_phase_d) begin
      dq_oe_d = 1'b1;
      we_n_d  = !(phase_start || we_window);
      if (req_f3 == F3_W) begin
        dq_d = hi_phase ? req_data[31:16] : req_data[15:0];
      end else if (req_f3 == F3_B) begin
        dq_d = {req_data[7:0], req_data[7:0]};
      end else begin
        dq_d = req_data[15:0];
      end
    end

    if (state_q == S_RD_LO && phase_last && f3_q != F3_W) begin
      ld_data_d = ld_extend(f3_q, addr_q[0], i_sram_dq, 16'h0000);
    end else if (state_q == S_RD_HI && phase_last) begin
      ld_data_d = ld_extend(f3_q, addr_q[0], lo_q, i_sram_dq);
    end
  end

  // Request capture and low-half read buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      f3_q       <= 3'b000;
      lo_q       <= '0;
      err_pend_q <= 1'b0;
    end else begin
      err_pend_q <= accept && req_bad;
      if (accept) begin
        addr_q <= i_lsu_addr;
        data_q <= i_st_data;
        f3_q   <= i_control;
      end
      if (state_q == S_RD_LO && phase_last) begin
        lo_q <= i_sram_dq;
      end
    end
  end

  // Output registers so all SRAM pins change only on the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready      <= 1'b1;
      o_ack        <= 1'b0;
      o_err        <= 1'b0;
      o_ld_data    <= '0;
      SRAM_ADDR    <= '0;
      SRAM_CE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_LB_N    <= 1'b1;
      SRAM_UB_N    <= 1'b1;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
    end else begin
      o_ready      <= ready_d;
      o_ack        <= ack_d;
      o_err        <= err_d;
      o_ld_data    <= ld_data_d;
      SRAM_ADDR    <= sram_addr_d;
      SRAM_CE_N    <= ce_n_d;
      SRAM_WE_N    <= we_n_d;
      SRAM_OE_N    <= oe_n_d;
      SRAM_LB_N    <= lb_n_d;
      SRAM_UB_N    <= ub_n_d;
      o_sram_dq    <= dq_d;
      o_sram_dq_oe <= dq_oe_d;
    end
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Scoreboard bench for sram_access_sequencer with a behavioural SRAM model.
module tb_sram_access_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst3;
  logic [18:0] lsu_addr, lsu_addr3;
  logic [31:0] st_data, st_data3;
  logic        wren, rden, wren3, rden3;
  logic [2:0]  control, control3;
  logic        ready, ack, err, ready3, ack3, err3;
  logic [31:0] ld_data, ld_data3;
  logic [17:0] sram_addr, sram_addr3;
  logic        ce_n, we_n, oe_n, lb_n, ub_n, ce_n3, we_n3, oe_n3, lb_n3, ub_n3;
  logic [15:0] dq_out, dq_in, dq_out3, dq_in3;
  logic        dq_oe, dq_oe3;

  logic [15:0] mem [0:1023] = '{default: 16'h0000};

  assign dq_in  = (!ce_n && !oe_n) ? mem[sram_addr[9:0]] : 16'h0000;
  assign dq_in3 = (!ce_n3 && !oe_n3) ? 16'h8001 : 16'h0000;

  sram_access_sequencer #(.WAIT_CYCLES(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_lsu_addr(lsu_addr), .i_st_data(st_data),
    .i_lsu_wren(wren), .i_lsu_rden(rden), .i_control(control),
    .o_ready(ready), .o_ack(ack), .o_err(err), .o_ld_data(ld_data),
    .SRAM_ADDR(sram_addr), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n), .o_sram_dq(dq_out), .o_sram_dq_oe(dq_oe),
    .i_sram_dq(dq_in)
  );

  sram_access_sequencer #(.WAIT_CYCLES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_lsu_addr(lsu_addr3), .i_st_data(st_data3),
    .i_lsu_wren(wren3), .i_lsu_rden(rden3), .i_control(control3),
    .o_ready(ready3), .o_ack(ack3), .o_err(err3), .o_ld_data(ld_data3),
    .SRAM_ADDR(sram_addr3), .SRAM_CE_N(ce_n3), .SRAM_WE_N(we_n3), .SRAM_OE_N(oe_n3),
    .SRAM_LB_N(lb_n3), .SRAM_UB_N(ub_n3), .o_sram_dq(dq_out3), .o_sram_dq_oe(dq_oe3),
    .i_sram_dq(dq_in3)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
    int          lat;
    time         t0;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          we_low = 0, ce_low = 0, oe3_low = 0;
  logic [17:0] wr_addr = '0, rd_addr3 = '0;
  logic [1:0]  wr_lanes = '0;
  logic [15:0] wr_dq = '0;
  time         last_t0 = 0, prev_t0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, want);
    end
  endtask

  // SRAM model and pin observation, sampled mid-cycle.
  always @(negedge clk) begin
    if (!ce_n) ce_low++;
    if (!ce_n && !we_n) begin
      we_low++;
      wr_addr  = sram_addr;
      wr_lanes = {ub_n, lb_n};
      wr_dq    = dq_out;
      if (!lb_n) mem[sram_addr[9:0]][7:0]  = dq_out[7:0];
      if (!ub_n) mem[sram_addr[9:0]][15:8] = dq_out[15:8];
    end
    if (!ce_n3 && !oe_n3) begin
      oe3_low++;
      rd_addr3 = sram_addr3;
    end
  end

  // Scoreboard monitor: every ack pops one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_err"}, 32'(err), 32'(e.err));
        check({e.name, "_lat"}, 32'(int'(($time - e.t0 - 5) / 10)), 32'(e.lat));
        if (e.chk_data) check({e.name, "_data"}, ld_data, e.data);
      end
    end
  end

  task automatic req(input string name, input logic w, input logic r, input logic [2:0] f3,
                     input logic [18:0] a, input logic [31:0] d, input logic [31:0] exp_data,
                     input logic exp_err, input logic chk_data, input int lat, input bit push);
    exp_t e;
    lsu_addr = a; st_data = d; wren = w; rden = r; control = f3;
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    if (!ready) begin
      check({name, "_ready_timeout"}, 32'd0, 32'd1);
      wren = 1'b0; rden = 1'b0;
      return;
    end
    @(posedge clk);
    e.name = name; e.data = exp_data; e.err = exp_err; e.chk_data = chk_data;
    e.lat = lat; e.t0 = $time;
    if (push) exp_q.push_back(e);
    prev_t0 = last_t0;
    last_t0 = $time;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || !ready); i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  w0, c0, o0;
    time t3;
    rst = 1'b1; rst3 = 1'b1;
    lsu_addr = '0; st_data = '0; wren = 1'b0; rden = 1'b0; control = 3'b000;
    lsu_addr3 = '0; st_data3 = '0; wren3 = 1'b0; rden3 = 1'b0; control3 = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_pins", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1f);
    check("rst_dq_oe", 32'(dq_oe), 32'd0);
    check("rst_dq", 32'(dq_out), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // Word store then load back
    w0 = we_low;
    req("sw", 1, 0, 3'b010, 19'h00010, 32'hDEADBEEF, 32'h0, 0, 0, 4, 1);
    drain();
    check("sw_mem8", 32'(mem[8]), 32'h0000BEEF);
    check("sw_mem9", 32'(mem[9]), 32'h0000DEAD);
    check("sw_we_cycles", 32'(we_low - w0), 32'd2);
    req("lw", 0, 1, 3'b010, 19'h00010, 32'h0, 32'hDEADBEEF, 0, 1, 4, 1);
    drain();
    repeat (4) begin
      @(negedge clk);
      check("ld_hold", ld_data, 32'hDEADBEEF);
    end

    // Byte lanes
    req("sb", 1, 0, 3'b000, 19'h00003, 32'h00000080, 32'h0, 0, 0, 2, 1);
    drain();
    check("sb_addr", 32'(wr_addr), 32'd1);
    check("sb_lanes_ub_lb", 32'(wr_lanes), 32'b01);
    check("sb_dq", 32'(wr_dq), 32'h00008080);
    check("sb_mem1", 32'(mem[1]), 32'h00008000);
    req("lb", 0, 1, 3'b000, 19'h00003, 32'h0, 32'hFFFFFF80, 0, 1, 2, 1);
    req("lbu", 0, 1, 3'b100, 19'h00003, 32'h0, 32'h00000080, 0, 1, 2, 1);
    drain();

    // Errors: no SRAM activity, ack one edge after accept
    c0 = ce_low;
    req("lw_mis", 0, 1, 3'b010, 19'h00002, 32'h0, 32'h0, 1, 0, 1, 1);
    req("lh_mis", 0, 1, 3'b001, 19'h00001, 32'h0, 32'h0, 1, 0, 1, 1);
    req("sbu_st", 1, 0, 3'b100, 19'h00004, 32'h0, 32'h0, 1, 0, 1, 1);
    req("f3_011", 0, 1, 3'b011, 19'h00000, 32'h0, 32'h0, 1, 0, 1, 1);
    drain();
    check("err_ce_quiet", 32'(ce_low - c0), 32'd0);

    // Both enables: write wins
    req("sw_both", 1, 1, 3'b010, 19'h00020, 32'h12345678, 32'h0, 0, 0, 4, 1);
    drain();
    check("both_mem10", 32'(mem[16]), 32'h00005678);
    check("both_mem11", 32'(mem[17]), 32'h00001234);

    // Requests raised while busy are held until IDLE
    req("lw_b2b", 0, 1, 3'b010, 19'h00020, 32'h0, 32'h12345678, 0, 1, 4, 1);
    req("lh_b2b", 0, 1, 3'b001, 19'h00022, 32'h0, 32'h00001234, 0, 1, 2, 1);
    check("word_spacing", 32'(last_t0 - prev_t0), 32'd60);
    req("lh_neg", 0, 1, 3'b001, 19'h00010, 32'h0, 32'hFFFFBEEF, 0, 1, 2, 1);
    check("half_spacing", 32'(last_t0 - prev_t0), 32'd40);
    req("lhu", 0, 1, 3'b101, 19'h00010, 32'h0, 32'h0000BEEF, 0, 1, 2, 1);
    drain();

    // Reset during the high write phase aborts without ack
    req("sw_rst", 1, 0, 3'b010, 19'h00030, 32'hCAFEF00D, 32'h0, 0, 0, 4, 0);
    for (int i = 0; i < 20 && !(!ce_n && dq_oe && sram_addr[0]); i++) @(negedge clk);
    check("reach_wr_hi", 32'(!ce_n && dq_oe && sram_addr[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pins", 32'({ce_n, we_n, oe_n, lb_n, ub_n}), 32'h1f);
    check("abort_dq_oe", 32'(dq_oe), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // WAIT_CYCLES=3 halfword load
    o0 = oe3_low;
    lsu_addr3 = 19'h00100; control3 = 3'b101; rden3 = 1'b1;
    for (int i = 0; i < 20 && !ready3; i++) @(negedge clk);
    @(posedge clk);
    t3 = $time;
    @(negedge clk);
    rden3 = 1'b0;
    for (int i = 0; i < 30 && !ack3; i++) @(negedge clk);
    check("lhu3_ack", 32'(ack3), 32'd1);
    check("lhu3_lat", 32'(int'(($time - t3 - 5) / 10)), 32'd4);
    check("lhu3_data", ld_data3, 32'h00008001);
    check("lhu3_err", 32'(err3), 32'd0);
    check("lhu3_addr", 32'(rd_addr3), 32'h00000080);
    check("lhu3_oe_cycles", 32'(oe3_low - o0), 32'd4);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
